layer7_loop_sched: RTL
======================

# layer7_loop_sched

Loop-nest scheduler for the layer-7 convolution datapath. On a start request it walks the four nested loop indices: u innermost, then l, then j, then outer tile t. It issues one index tuple per non-stalled cycle with a valid strobe and per-level wrap pulses. After the last tuple it waits a fixed pipeline-drain interval and raises a one-cycle done. It replaces the free-running per-index counters with a single sequenced controller that sits between the layer top-level control and the layer-7 MAC/address generators.

## Interface
Parameters:
- U_MAX, 4, last value of u (innermost index)
- L_MAX, 3, last value of l
- J_MAX, 2, last value of j
- T_MAX, 1, last value of t (outermost tile index)
- DRAIN_CYC, 3, cycles to wait after the last tuple for the MAC pipeline to flush (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a layer pass; honored only in IDLE
- stall  in  1  hold the current tuple (datapath back-pressure)
- abort  in  1  synchronous abandon of the pass
- busy  out  1  high in RUN and DRAIN
- valid  out  1  current index tuple is live (RUN and !stall)
- u  out  $clog2(U_MAX+1)  index u
- l  out  $clog2(L_MAX+1)  index l
- j  out  $clog2(J_MAX+1)  index j
- t  out  $clog2(T_MAX+1)  index t
- u_wrap  out  1  valid && u==U_MAX
- l_wrap  out  1  u_wrap && l==L_MAX
- j_wrap  out  1  l_wrap && j==J_MAX
- last  out  1  j_wrap && t==T_MAX (final tuple of the pass)
- done  out  1  one-cycle pulse at pass completion

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - all indices are 0.
  - start=1 -> RUN.
- RUN:
  - Each cycle with stall=0 consumes the tuple: u increments; when u_wrap, u returns to 0 and l increments; the same pattern carries into j and then t.
  - Index width is exact; all compares are against the parameter values, never against the natural wrap of the width.
  - stall=1 freezes all indices and forces valid=0, so every wrap pulse is 0.
  - last with stall=0 -> DRAIN, with all indices returned to 0.
- DRAIN:
  - A down-counter loaded with DRAIN_CYC-1 on entry.
  - Exit to DONE when it reaches 0.
  - stall is ignored.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
- Wrap pulses are combinational from state, indices and stall; they are not registered.
- start while busy or in DONE: ignored, never queued.
- abort=1 in any state takes priority over start, stall and state progress:
  - next state IDLE, indices cleared.
  - no done pulse for the aborted pass.
- start and abort together in IDLE: stay IDLE.

## Timing
- Reset values: state IDLE; u=l=j=t=0; busy=valid=done=0; all wraps 0.
- rst asserted mid-pass: the same values, immediately (asynchronous).
- Start latency: start sampled at edge E0 -> valid=1 with tuple (0,0,0,0) in the cycle after E0.
- Each non-stalled RUN cycle presents exactly one tuple. A stalled cycle adds one cycle and presents no tuple.
- Unstalled pass length: N=(U_MAX+1)(L_MAX+1)(J_MAX+1)(T_MAX+1) valid cycles.
- done rises N+DRAIN_CYC+1 cycles after start is accepted, plus one cycle per stalled RUN cycle.
- Back-to-back passes: a new start is accepted in IDLE on the cycle after done. The minimum gap between passes is 1 cycle.
- Degenerate all-MAX=0 configuration: the first tuple is also last; RUN lasts one cycle.

## Structure
- Shared package layer7_sched_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - default loop-bound constants for layer 7, reused by the address generators
- One sub-module, loop_counter_l7: generic wrap counter.
  - Parameter MAX.
  - Inputs: inc, clr.
  - Outputs: count, at_max.
  - Instantiated four times; the carry chain is built in the top module.
- The FSM and drain counter live in the top module.

## Test plan
- Defaults, start pulse, stall=0:
  - 120 valid cycles; tuples in u-fastest order.
  - u_wrap 24×, l_wrap 6×, j_wrap 2×, last 1× on tuple (4,3,2,1).
  - done exactly 124 cycles after start acceptance.
- Stall held for 5 cycles at tuple (4,3,0,0):
  - indices frozen; valid=0 and no wraps during the stall.
  - l_wrap fires on release.
  - done delayed by exactly 5 cycles.
- start re-asserted during RUN and DRAIN: ignored; exactly one done; then start in the cycle after done begins a second clean pass from (0,0,0,0).
- abort at tuple (2,1,1,0): next cycle IDLE, indices 0, busy=0, no done pulse.
- Async rst low mid-DRAIN: outputs go to reset values immediately; no done after rst is released.
- Parameter override U_MAX=L_MAX=J_MAX=T_MAX=0, DRAIN_CYC=1: one valid cycle with last=1, done 3 cycles after start.

Source files
------------

// File: rtl/layer7_sched_pkg.sv
// layer7_sched_pkg: shared scheduler state encoding, layer-7 loop bounds and width helper
package layer7_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int L7_U_MAX = 4;
  localparam int L7_L_MAX = 3;
  localparam int L7_J_MAX = 2;
  localparam int L7_T_MAX = 1;
  localparam int L7_DRAIN_CYC = 3;
  // A bound of 0 still needs one storage bit
  function automatic int cw(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/loop_counter_l7.sv
// loop_counter_l7: wrap counter 0..MAX with synchronous clear, carry taken from at_max
module loop_counter_l7
  import layer7_sched_pkg::*;
#(
  parameter int MAX = 1,
  localparam int W = cw(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);
  logic [W-1:0] count_q, count_d;
  assign at_max = count_q == W'(MAX);
  assign count = count_q;
  always_comb count_d = clr ? '0 : inc ? (at_max ? '0 : count_q + 1'b1) : count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/layer7_loop_sched.sv
// layer7_loop_sched: sequences the u/l/j/t loop nest, then drains the MAC pipeline and pulses done
module layer7_loop_sched
  import layer7_sched_pkg::*;
#(
  parameter int U_MAX = L7_U_MAX,
  parameter int L_MAX = L7_L_MAX,
  parameter int J_MAX = L7_J_MAX,
  parameter int T_MAX = L7_T_MAX,
  parameter int DRAIN_CYC = L7_DRAIN_CYC,
  localparam int DW = cw(DRAIN_CYC - 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                abort,
  output logic                busy,
  output logic                valid,
  output logic [cw(U_MAX)-1:0] u,
  output logic [cw(L_MAX)-1:0] l,
  output logic [cw(J_MAX)-1:0] j,
  output logic [cw(T_MAX)-1:0] t,
  output logic                u_wrap,
  output logic                l_wrap,
  output logic                j_wrap,
  output logic                last,
  output logic                done
);
  state_e state_q;
  logic [DW-1:0] drain_q;
  logic u_max, l_max, j_max, t_max, clr;
  assign valid = state_q == RUN && !stall;
  assign u_wrap = valid && u_max;
  assign l_wrap = u_wrap && l_max;
  assign j_wrap = l_wrap && j_max;
  assign last = j_wrap && t_max;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  // Outside RUN the indices are held at zero; the final tuple also wraps them there naturally
  assign clr = abort || state_q != RUN;
  loop_counter_l7 #(.MAX(U_MAX)) u_cnt (.clk(clk), .rst(rst), .inc(valid),  .clr(clr), .count(u), .at_max(u_max));
  loop_counter_l7 #(.MAX(L_MAX)) l_cnt (.clk(clk), .rst(rst), .inc(u_wrap), .clr(clr), .count(l), .at_max(l_max));
  loop_counter_l7 #(.MAX(J_MAX)) j_cnt (.clk(clk), .rst(rst), .inc(l_wrap), .clr(clr), .count(j), .at_max(j_max));
  loop_counter_l7 #(.MAX(T_MAX)) t_cnt (.clk(clk), .rst(rst), .inc(j_wrap), .clr(clr), .count(t), .at_max(t_max));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN:
          if (last) begin
            state_q <= DRAIN;
            drain_q <= DW'(DRAIN_CYC - 1);
          end
        DRAIN:
          if (drain_q == '0) state_q <= DONE;
          else drain_q <= drain_q - 1'b1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule
